// File: rtl/debounce_edge.sv
// debounce_edge: glitch filter with registered rise/fall strobes.
// The input level is accepted only after STABLE_CYCLES consecutive samples
// that differ from the current debounced level. Partial runs are discarded.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on d, which
// adds 2 clocks to every latency. Without it, d must already be in the clk
// domain.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RST_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic db,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam state_t RST_STATE = RST_LEVEL ? STABLE_HI : STABLE_LO;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync_1, sync_2;

  // Two-flop synchronizer bringing d into the clk domain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_1 <= RST_LEVEL;
      sync_2 <= RST_LEVEL;
    end else begin
      sync_1 <= d;
      sync_2 <= sync_1;
    end
  end

  assign s = sync_2;
`else
  assign s = d;
`endif

  // Qualification FSM with run-length counter; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      db    <= RST_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            if (LAST == '0) begin
              state <= STABLE_HI;
              db    <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PEND_HI;
              busy  <= 1'b1;
              cnt   <= CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        PEND_HI: begin
          if (!s) begin
            // Glitch reject: run ended early, level unchanged.
            state <= STABLE_LO;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_HI;
            busy  <= 1'b0;
            db    <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (LAST == '0) begin
              state <= STABLE_LO;
              db    <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PEND_LO;
              busy  <= 1'b1;
              cnt   <= CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        PEND_LO: begin
          if (s) begin
            state <= STABLE_HI;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_LO;
            busy  <= 1'b0;
            db    <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RST_STATE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
